mcht_rx_dec: RTL and testbench
==============================

# mcht_rx_dec

Manchester line decoder for the receive half of the `tt_um_patrick_lin_git_mcht_trx` transceiver. It takes the raw serial line from a dedicated input pin, oversamples it with the system clock, recovers bit timing from the mandatory mid-bit transitions, and delivers each decoded byte with a one-cycle valid strobe. It is the counterpart of the transceiver's Manchester encoder and uses the same framing, bit convention and bit period.

## Interface
- `SPB`, 16: clock cycles per Manchester bit; multiple of 4, minimum 8.
- `DW`, 8: data bits per frame.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  decoder enable; low forces IDLE and ignores the line.
- `rxd`  in  1  asynchronous Manchester line input, idle low.
- `dout`  out  DW  last decoded byte; holds its value until the next good frame.
- `dout_vld`  out  1  one-cycle strobe; `dout` is valid in the same cycle.
- `err`  out  1  one-cycle strobe on a code violation.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Line code: bit 1 is low in the first half and high in the second; bit 0 is high then low. The idle line is low.
- Frame: one start bit (1), then DW data bits LSB-first, then at least SPB cycles of idle low.
- Input path: a 2-FF synchronizer, then a registered edge detector on the synchronized signal `rs`. All timing below is relative to `rs`.
- Phase counter `cnt` runs 0..SPB-1 and wraps. Sample points: S1 at cnt == SPB/4 (first half), S2 at cnt == 3·SPB/4 (second half).
- States:
  - IDLE: waits for a rising edge on `rs`, which is the mid-bit edge of the start bit. On that edge, `cnt` loads SPB/2+1, the bit index clears, and the state goes to DATA. Falling edges and a constant high line are ignored.
  - DATA: `cnt` increments each cycle.
    - Resync: an edge seen while SPB/4 < cnt < 3·SPB/4 loads cnt = SPB/2+1.
    - Edges outside that window are bit-boundary edges and are ignored.
    - At S1, capture h1 = rs. At S2, decoded bit = rs (second-half level).
    - If rs == h1 at S2, it is a code violation: pulse `err` next cycle and go to STOP.
    - Otherwise shift the bit in, LSB first.
    - At the S2 of bit DW-1, register `dout`, pulse `dout_vld` next cycle, and go to STOP.
    - The start bit is not re-sampled. Bit 0 begins when cnt wraps after the start edge.
  - STOP: counts consecutive low `rs` cycles. Any high cycle restarts the count. After SPB consecutive low cycles, go to IDLE.
- `en` low or `rst`: state IDLE, counters cleared, no strobes. `dout` keeps its value on `en` low and clears only on `rst`.
- `dout_vld` and `err` are never high in the same cycle.

## Timing
- Reset values: `dout` = 0, `dout_vld` = 0, `err` = 0, `busy` = 0, state IDLE, `cnt` = 0.
- Synchronizer latency: 2 cycles from `rxd` to `rs`, plus 1 cycle for edge detection.
- `dout_vld` rises exactly 1 cycle after the S2 cycle of the last data bit. That is about 3 + SPB/2 + DW·SPB − SPB/4 cycles after the start-bit mid edge on `rxd`.
- `busy` rises the cycle after the start edge is detected. It falls the cycle after STOP completes.
- Jitter tolerance: a transmitter bit period of SPB ± SPB/8 decodes correctly, because resync happens every bit.
- Frame spacing: a new start edge is accepted only after STOP completes, i.e. at least SPB idle cycles after the last data bit.
- Reset mid-frame: takes effect on the next clock edge. No `dout_vld` or `err` is emitted for the aborted frame.

## Test plan
- SPB=16, send 0xA5 with an exact 16-cycle bit period -> `dout` = 0xA5, `dout_vld` high for exactly 1 cycle, `err` never high, `busy` low again 16 idle cycles after the frame.
- Send 0x00, then 0xFF, with 32 idle cycles between frames -> two `dout_vld` pulses carrying 0x00 and 0xFF in order.
- Send 0x3C with bit 3 held high for the whole bit period -> single `err` pulse, no `dout_vld`, `dout` keeps its prior value. Then send 0x3C cleanly after 16 idle cycles -> decoded correctly.
- Send 0x5A at a 14-cycle bit period, then at an 18-cycle bit period -> both frames decode to 0x5A with no `err`.
- Assert `rst` for 1 cycle during data bit 4 of a 0x77 frame -> all outputs 0 next cycle, no strobe. The following 0x81 frame decodes correctly.
- Drive `en` low during bit 2 of a frame -> `busy` drops and no strobe is emitted. Raise `en` while the line is idle and send 0xC3 -> decoded correctly.

Source files
------------

// File: rtl/mcht_rx_dec.sv
// Manchester receive decoder: oversamples the line, locks bit timing to the
// mandatory mid-bit transitions and emits each decoded byte with a valid strobe.
module mcht_rx_dec #(
   parameter int SPB = 16,
   parameter int DW  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          rxd,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   output logic          err,
   output logic          busy
);

   localparam int CW = $clog2(SPB);
   localparam int IW = $clog2(DW);
   localparam int LW = $clog2(SPB + 1);

   localparam logic [CW-1:0] C_S1  = CW'(SPB / 4);
   localparam logic [CW-1:0] C_S2  = CW'(3 * SPB / 4);
   localparam logic [CW-1:0] C_RS  = CW'(SPB / 2 + 1);
   localparam logic [CW-1:0] C_MAX = CW'(SPB - 1);
   localparam logic [LW-1:0] L_MAX = LW'(SPB);

   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

   state_t         state, state_nx;
   logic           rx_m, rs, rs_d;
   logic           rise, edge_det;
   logic [CW-1:0]  cnt;
   logic [IW-1:0]  bit_idx;
   logic [LW-1:0]  lo_cnt;
   logic           in_start;
   logic           h1;
   logic [DW-2:0]  sreg;
   logic           armed, s1_pt, s2_pt;
   logic           start, viol, last;

   assign rise     = rs & ~rs_d;
   assign edge_det = rs ^ rs_d;
   // Line must have been low for a full bit time before a start edge counts;
   // this also keeps the tail of a frame cut by reset/enable from re-triggering.
   assign armed    = (lo_cnt == L_MAX);
   assign s1_pt    = (cnt == C_S1) && !in_start;
   assign s2_pt    = (cnt == C_S2) && !in_start;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b0;
         rs   <= 1'b0;
         rs_d <= 1'b0;
      end else begin
         rx_m <= rxd;
         rs   <= rx_m;
         rs_d <= rs;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !en) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      viol     = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (rise && armed) begin
               state_nx = DATA;
               start    = 1'b1;
            end
         end
         DATA: begin
            if (s2_pt) begin
               if (rs == h1) begin
                  viol     = 1'b1;
                  state_nx = STOP;
               end else if (bit_idx == IW'(DW - 1)) begin
                  last     = 1'b1;
                  state_nx = STOP;
               end
            end
         end
         STOP: begin
            if (armed) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (!en) begin
         state_nx = IDLE;
         start    = 1'b0;
         viol     = 1'b0;
         last     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         bit_idx  <= '0;
         lo_cnt   <= '0;
         in_start <= 1'b0;
         h1       <= 1'b0;
         sreg     <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
         err      <= 1'b0;
      end else if (!en) begin
         cnt      <= '0;
         bit_idx  <= '0;
         lo_cnt   <= '0;
         in_start <= 1'b0;
         dout_vld <= 1'b0;
         err      <= 1'b0;
      end else begin
         dout_vld <= last;
         err      <= viol;

         if (rs)                  lo_cnt <= '0;
         else if (lo_cnt != L_MAX) lo_cnt <= lo_cnt + LW'(1);

         if (start) begin
            cnt      <= C_RS;
            bit_idx  <= '0;
            in_start <= 1'b1;
         end else if (state == DATA) begin
            // Mid-bit edges re-centre the phase; boundary edges fall outside the window.
            if (edge_det && (cnt > C_S1) && (cnt < C_S2)) begin
               cnt <= C_RS;
            end else if (cnt == C_MAX) begin
               cnt      <= '0;
               in_start <= 1'b0;
            end else begin
               cnt <= cnt + CW'(1);
            end
            if (s1_pt) h1 <= rs;
            if (s2_pt && (rs != h1)) begin
               sreg    <= {rs, sreg[DW-2:1]};
               bit_idx <= bit_idx + IW'(1);
            end
            if (last) dout <= {rs, sreg};
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mcht_rx_dec.sv
// Directed bench for mcht_rx_dec: drives Manchester frames on rxd and checks
// decoded bytes, strobes, busy and reset/enable behaviour.
module tb_mcht_rx_dec;

   localparam int SPB = 16;
   localparam int DW  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b1;
   logic          rxd = 1'b0;
   logic [DW-1:0] dout;
   logic          dout_vld, err, busy;

   int checks = 0;
   int errs   = 0;
   int cyc    = 0;
   int t_mid  = 0;

   int vld_cycles = 0, vld_pulses = 0, err_cycles = 0, err_pulses = 0;
   int overlap = 0, last_vld_cyc = 0;
   logic vld_prev = 1'b0, err_prev = 1'b0, busy_seen = 1'b0;
   int v0, e0, vc0, ec0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];

   mcht_rx_dec #(.SPB(SPB), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .rxd      (rxd),
      .dout     (dout),
      .dout_vld (dout_vld),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dout_vld) begin
         vld_cycles++;
         got_q.push_back(dout);
         last_vld_cyc = cyc;
         if (!vld_prev) vld_pulses++;
      end
      if (err) begin
         err_cycles++;
         if (!err_prev) err_pulses++;
      end
      if (dout_vld && err) overlap++;
      if (busy) busy_seen = 1'b1;
      vld_prev = dout_vld;
      err_prev = err;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b0;
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // bad selects a data bit held high for the whole period; -2 means none
   task automatic send_frame(input logic [7:0] d, input int per, input int bad);
      int   h1 = per / 2;
      int   h2 = per - per / 2;
      logic b;
      for (int i = -1; i < DW; i++) begin
         b = (i < 0) ? 1'b1 : d[i[2:0]];
         if (i == bad) begin
            rxd = 1'b1;
            repeat (per) tick();
         end else begin
            rxd = ~b;
            repeat (h1) tick();
            rxd = b;
            if (i < 0) t_mid = cyc;
            repeat (h2) tick();
         end
      end
      rxd = 1'b0;
   endtask

   task automatic snap();
      v0  = vld_pulses;
      e0  = err_pulses;
      vc0 = vld_cycles;
      ec0 = err_cycles;
      busy_seen = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_dout", dout, 0);
      chk("rst_vld", dout_vld, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      idle(24);

      // clean 0xA5 at nominal period
      snap();
      send_frame(8'hA5, SPB, -2);
      exp_q.push_back(8'hA5);
      idle(22);
      chk("a5_vld_pulses", vld_pulses - v0, 1);
      chk("a5_vld_width", vld_cycles - vc0, 1);
      chk("a5_err", err_pulses - e0, 0);
      chk("a5_dout", dout, 8'hA5);
      chk("a5_latency", last_vld_cyc - t_mid, 3 + SPB / 2 + DW * SPB - SPB / 4);
      chk("a5_busy_seen", busy_seen, 1);
      chk("a5_busy_end", busy, 0);

      // back-to-back 0x00 then 0xFF
      snap();
      send_frame(8'h00, SPB, -2);
      exp_q.push_back(8'h00);
      idle(32);
      chk("x00_dout", dout, 8'h00);
      send_frame(8'hFF, SPB, -2);
      exp_q.push_back(8'hFF);
      idle(32);
      chk("pair_vld_pulses", vld_pulses - v0, 2);
      chk("pair_err", err_pulses - e0, 0);
      chk("xff_dout", dout, 8'hFF);

      // code violation in bit 3, then the same byte cleanly
      snap();
      send_frame(8'h3C, SPB, 3);
      idle(16);
      chk("viol_err_pulses", err_pulses - e0, 1);
      chk("viol_err_width", err_cycles - ec0, 1);
      chk("viol_vld", vld_pulses - v0, 0);
      chk("viol_dout_kept", dout, 8'hFF);
      snap();
      send_frame(8'h3C, SPB, -2);
      exp_q.push_back(8'h3C);
      idle(24);
      chk("x3c_vld", vld_pulses - v0, 1);
      chk("x3c_err", err_pulses - e0, 0);
      chk("x3c_dout", dout, 8'h3C);

      // bit period jitter: 14 and 18 cycles
      snap();
      send_frame(8'h5A, 14, -2);
      exp_q.push_back(8'h5A);
      idle(24);
      chk("fast_dout", dout, 8'h5A);
      send_frame(8'h5A, 18, -2);
      exp_q.push_back(8'h5A);
      idle(24);
      chk("jit_vld", vld_pulses - v0, 2);
      chk("jit_err", err_pulses - e0, 0);

      // reset during data bit 4 of 0x77
      snap();
      fork
         send_frame(8'h77, SPB, -2);
         begin
            repeat (SPB + 4 * SPB + SPB / 2) tick();
            chk("pre_rst_busy", busy, 1);
            rst = 1'b1;
            tick();
            chk("mid_rst_dout", dout, 0);
            chk("mid_rst_vld", dout_vld, 0);
            chk("mid_rst_err", err, 0);
            chk("mid_rst_busy", busy, 0);
            rst = 1'b0;
         end
      join
      idle(24);
      chk("abort_vld", vld_pulses - v0, 0);
      chk("abort_err", err_pulses - e0, 0);
      send_frame(8'h81, SPB, -2);
      exp_q.push_back(8'h81);
      idle(24);
      chk("x81_vld", vld_pulses - v0, 1);
      chk("x81_dout", dout, 8'h81);

      // enable dropped during bit 2
      snap();
      fork
         send_frame(8'h66, SPB, -2);
         begin
            repeat (SPB + 2 * SPB + SPB / 2) tick();
            chk("pre_en_busy", busy, 1);
            en = 1'b0;
            tick();
            chk("en_low_busy", busy, 0);
         end
      join
      idle(10);
      chk("en_low_dout_kept", dout, 8'h81);
      en = 1'b1;
      idle(24);
      chk("en_abort_vld", vld_pulses - v0, 0);
      chk("en_abort_err", err_pulses - e0, 0);
      send_frame(8'hC3, SPB, -2);
      exp_q.push_back(8'hC3);
      idle(24);
      chk("xc3_vld", vld_pulses - v0, 1);
      chk("xc3_dout", dout, 8'hC3);

      chk("vld_err_overlap", overlap, 0);
      chk("n_frames", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) chk($sformatf("frame%0d", i), got_q[i], exp_q[i]);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
